// File: rtl/seq_mult_8bit_pkg.sv
// Shared definitions for the sequential 8x8 multiplier: FSM states, per-state
// partial-product shift amounts and the start-to-done latency.
package seq_mult_8bit_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    P0   = 3'd1,
    P1   = 3'd2,
    P2   = 3'd3,
    P3   = 3'd4,
    FIN  = 3'd5
  } state_e;

  localparam logic [3:0] SH_P0 = 4'd0;
  localparam logic [3:0] SH_P1 = 4'd4;
  localparam logic [3:0] SH_P2 = 4'd4;
  localparam logic [3:0] SH_P3 = 4'd8;

  // Clock edges from the accepting start edge to prod/done valid.
  localparam int unsigned MULT_LATENCY = 5;

endpackage

// File: rtl/seq_mult_8bit_arr_mult.sv
// 4x4 unsigned combinational array multiplier: one AND row per multiplier bit,
// each row shifted by its bit weight and summed.
module seq_mult_8bit_arr_mult (
  input  logic [3:0] i_a,
  input  logic [3:0] i_b,
  output logic [7:0] o_p
);

  logic [7:0] w_row0;
  logic [7:0] w_row1;
  logic [7:0] w_row2;
  logic [7:0] w_row3;

  assign w_row0 = {4'b0000, i_a & {4{i_b[0]}}};
  assign w_row1 = {3'b000, i_a & {4{i_b[1]}}, 1'b0};
  assign w_row2 = {2'b00, i_a & {4{i_b[2]}}, 2'b00};
  assign w_row3 = {1'b0, i_a & {4{i_b[3]}}, 3'b000};

  // 15*15 = 225 fits in 8 bits, so the sum never overflows.
  assign o_p = w_row0 + w_row1 + w_row2 + w_row3;

endmodule

// File: rtl/seq_mult_8bit.sv
// Multi-cycle 8x8 multiplier: sign-magnitude operands, four nibble partial
// products through the 4x4 array, result re-signed in FIN. start/busy/done handshake.
module seq_mult_8bit
  import seq_mult_8bit_pkg::*;
#(
  parameter bit SIGNED_EN = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        signed_op,
  input  logic [7:0]  a,
  input  logic [7:0]  b,
  output logic        busy,
  output logic        done,
  output logic [15:0] prod,
  output state_e      dbg_state
);

  state_e      r_state;
  logic [7:0]  r_ma;
  logic [7:0]  r_mb;
  logic        r_neg;
  logic [15:0] r_acc;
  logic        r_busy;
  logic        r_done;
  logic [15:0] r_prod;

  logic        w_sgn;
  logic [7:0]  w_ma;
  logic [7:0]  w_mb;
  logic [3:0]  w_na;
  logic [3:0]  w_nb;
  logic [3:0]  w_shift;
  logic [7:0]  w_pp;
  logic [15:0] w_pp_sh;

  // A magnitude of 128 (from -128) still fits in 8 unsigned bits.
  assign w_sgn = SIGNED_EN && signed_op;
  assign w_ma  = (w_sgn && a[7]) ? (~a + 8'd1) : a;
  assign w_mb  = (w_sgn && b[7]) ? (~b + 8'd1) : b;

  always_comb begin
    w_na    = 4'h0;
    w_nb    = 4'h0;
    w_shift = 4'd0;
    case (r_state)
      P0: begin w_na = r_ma[3:0]; w_nb = r_mb[3:0]; w_shift = SH_P0; end
      P1: begin w_na = r_ma[3:0]; w_nb = r_mb[7:4]; w_shift = SH_P1; end
      P2: begin w_na = r_ma[7:4]; w_nb = r_mb[3:0]; w_shift = SH_P2; end
      P3: begin w_na = r_ma[7:4]; w_nb = r_mb[7:4]; w_shift = SH_P3; end
      default: begin w_na = 4'h0; w_nb = 4'h0; w_shift = 4'd0; end
    endcase
  end

  seq_mult_8bit_arr_mult u_arr_mult (
    .i_a (w_na),
    .i_b (w_nb),
    .o_p (w_pp)
  );

  assign w_pp_sh = {8'h00, w_pp} << w_shift;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_ma    <= 8'h00;
      r_mb    <= 8'h00;
      r_neg   <= 1'b0;
      r_acc   <= 16'h0000;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_prod  <= 16'h0000;
    end else begin
      case (r_state)
        IDLE: begin
          r_done <= 1'b0;
          if (start) begin
            r_ma    <= w_ma;
            r_mb    <= w_mb;
            r_neg   <= w_sgn && (a[7] ^ b[7]);
            r_acc   <= 16'h0000;
            r_busy  <= 1'b1;
            r_state <= P0;
          end
        end
        P0: begin r_acc <= r_acc + w_pp_sh; r_state <= P1; end
        P1: begin r_acc <= r_acc + w_pp_sh; r_state <= P2; end
        P2: begin r_acc <= r_acc + w_pp_sh; r_state <= P3; end
        P3: begin r_acc <= r_acc + w_pp_sh; r_state <= FIN; end
        FIN: begin
          // Negating a zero accumulator wraps back to 0, so no negative zero.
          r_prod  <= r_neg ? (~r_acc + 16'd1) : r_acc;
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign busy      = r_busy;
  assign done      = r_done;
  assign prod      = r_prod;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_seq_mult_8bit.sv
// Bench for seq_mult_8bit: a signed-enabled and an unsigned-only instance share
// stimulus; each done is scored against an arithmetic reference model.
module tb_seq_mult_8bit;
  import seq_mult_8bit_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        signed_op;
  logic [7:0]  a;
  logic [7:0]  b;
  logic        busy_s, done_s, busy_u, done_u;
  logic [15:0] prod_s, prod_u;
  state_e      state_s, state_u;

  int n_checks = 0;
  int n_errors = 0;

  logic [15:0] exp_q_s[$];
  logic [15:0] exp_q_u[$];
  logic [15:0] last_s, last_u;

  seq_mult_8bit #(.SIGNED_EN(1'b1)) dut_s (
    .clk(clk), .rst_n(rst_n), .start(start), .signed_op(signed_op),
    .a(a), .b(b), .busy(busy_s), .done(done_s), .prod(prod_s), .dbg_state(state_s)
  );

  seq_mult_8bit #(.SIGNED_EN(1'b0)) dut_u (
    .clk(clk), .rst_n(rst_n), .start(start), .signed_op(signed_op),
    .a(a), .b(b), .busy(busy_u), .done(done_u), .prod(prod_u), .dbg_state(state_u)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [15:0] ref_mult(input logic [7:0] x, input logic [7:0] y,
                                           input logic s, input logic en);
    int p;
    if (s && en) p = $signed(x) * $signed(y);
    else         p = int'(x) * int'(y);
    return p[15:0];
  endfunction

  // scoreboard: every done pops one expected product
  always @(negedge clk) begin
    if (done_s) begin
      if (exp_q_s.size() == 0) check("spurious_done_s", 1, 0);
      else check("prod_s", prod_s, exp_q_s.pop_front());
    end
    if (done_u) begin
      if (exp_q_u.size() == 0) check("spurious_done_u", 1, 0);
      else check("prod_u", prod_u, exp_q_u.pop_front());
    end
    if (busy_s && done_s) check("busy_and_done_s", 1, 0);
    if (busy_u && done_u) check("busy_and_done_u", 1, 0);
  end

  // driver: present one start for one edge; returns #1 after the accepting edge
  task automatic issue(input logic [7:0] x, input logic [7:0] y, input logic s);
    a         = x;
    b         = y;
    signed_op = s;
    start     = 1'b1;
    last_s    = ref_mult(x, y, s, 1'b1);
    last_u    = ref_mult(x, y, s, 1'b0);
    exp_q_s.push_back(last_s);
    exp_q_u.push_back(last_u);
    @(posedge clk);
    #1;
    start = 1'b0;
    a     = $urandom_range(0, 255);
    b     = $urandom_range(0, 255);
  endtask

  // count edges until done; busy must hold until then and both instances agree on timing
  task automatic wait_done(input int k0, input string tag);
    int k;
    k = k0;
    while (!done_s && k < 20) begin
      check({tag, "_busy"}, busy_s, 1);
      @(posedge clk);
      #1;
      k++;
    end
    check({tag, "_latency"}, k, 5);
    check({tag, "_done_u"}, done_u, 1);
    check({tag, "_busy_at_done"}, busy_s, 0);
  endtask

  task automatic run_op(input logic [7:0] x, input logic [7:0] y, input logic s, input string tag);
    issue(x, y, s);
    wait_done(0, tag);
    @(posedge clk);
    #1;
    check({tag, "_done_pulse"}, done_s, 0);
    check({tag, "_hold_s"}, prod_s, last_s);
    check({tag, "_hold_u"}, prod_u, last_u);
  endtask

  initial begin
    rst_n     = 1'b0;
    start     = 1'b0;
    signed_op = 1'b0;
    a         = 8'h00;
    b         = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", busy_s, 0);
    check("rst_done", done_s, 0);
    check("rst_prod", prod_s, 16'h0000);
    check("rst_state", state_s, IDLE);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // directed cases
    run_op(8'd13, 8'd11, 1'b0, "u13x11");
    check("u13x11_val", prod_s, 16'h008F);
    run_op(8'd255, 8'd255, 1'b0, "umax");
    check("umax_val", prod_s, 16'hFE01);
    run_op(8'h80, 8'h80, 1'b1, "s_m128sq");
    check("s_m128sq_val", prod_s, 16'h4000);
    run_op(8'hFD, 8'd7, 1'b1, "s_m3x7");
    check("s_m3x7_val", prod_s, 16'hFFEB);
    run_op(8'h00, 8'h80, 1'b1, "s_zero");
    check("s_zero_val", prod_s, 16'h0000);
    run_op(8'hFF, 8'd2, 1'b1, "unsigned_build");
    check("unsigned_build_val", prod_u, 16'h01FE);

    // start while busy is ignored
    issue(8'd6, 8'd7, 1'b0);
    @(posedge clk);
    #1;
    a = 8'd1; b = 8'd1; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done(2, "ignore_start");
    check("ignore_start_val", prod_s, 16'd42);
    repeat (8) @(posedge clk);
    #1;

    // back-to-back: start during the done cycle
    issue(8'd9, 8'd9, 1'b0);
    wait_done(0, "b2b_first");
    issue(8'd2, 8'd3, 1'b0);
    check("b2b_done_cleared", done_s, 0);
    wait_done(0, "b2b_second");
    check("b2b_val", prod_s, 16'd6);
    @(posedge clk);
    #1;

    // asynchronous reset during P2
    issue(8'd200, 8'd100, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #3;
    check("pre_rst_busy", busy_s, 1);
    rst_n = 1'b0;
    #1;
    check("async_rst_busy", busy_s, 0);
    check("async_rst_done", done_s, 0);
    check("async_rst_prod", prod_s, 16'h0000);
    check("async_rst_state", state_s, IDLE);
    exp_q_s.delete();
    exp_q_u.delete();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    check("post_rst_prod", prod_s, 16'h0000);
    run_op(8'd5, 8'd5, 1'b0, "after_rst");
    check("after_rst_val", prod_s, 16'd25);

    // randomized operands and signedness
    for (int i = 0; i < 40; i++) begin
      logic [7:0] x, y;
      logic s;
      x = 8'($urandom_range(0, 255));
      y = 8'($urandom_range(0, 255));
      s = 1'($urandom_range(0, 1));
      if (i % 10 == 0) x = 8'h80;
      if (i % 10 == 5) y = 8'h00;
      run_op(x, y, s, "rand");
    end

    repeat (3) @(posedge clk);
    #1;
    check("queue_empty_s", exp_q_s.size(), 0);
    check("queue_empty_u", exp_q_u.size(), 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
